control_unit_ws: RTL and testbench

CONTROL_UNIT_WS -- requirements
Module: control_unit_ws

---
 rtl/control_unit_ws.sv | 144 ++++++++++++++
 tb/tb_control_unit_ws.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_ws.sv
// Multi-cycle core sequencer: FETCH/EXEC/MEM/WB with HALT, single-step and FAULT handling.
// Outputs are decoded combinationally from the current state and opcode.
module control_unit_ws #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32,
    parameter bit STEP_EN     = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             continue_i,
    input  logic [3:0]       opcode_i,
    input  logic             mem_ready_i,
    output logic             loadPC_o,
    output logic             writeReg_o,
    output logic             MemEn_o,
    output logic             MemWen_o,
    output logic             IMMsel_o,
    output logic [1:0]       DataSel_o,
    output logic [2:0]       BRANCH_o,
    output logic             pwr_o,
    output logic             halted_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] retired_o
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4,
        S_STEP  = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             continue_q;
    logic             cont_edge;

    logic is_alur, is_alui, is_load, is_store, is_br, is_cmov, is_halt, is_illegal;
    logic       imm_sel;
    logic [2:0] br_mode;

    assign is_alur    = (opcode_i == 4'b0000);
    assign is_alui    = (opcode_i == 4'b0001);
    assign is_load    = (opcode_i == 4'b0010);
    assign is_store   = (opcode_i == 4'b0011);
    assign is_br      = (opcode_i[3:2] == 2'b01);
    assign is_cmov    = (opcode_i == 4'b1000);
    assign is_halt    = (opcode_i == 4'b1111);
    assign is_illegal = ~(is_alur | is_alui | is_load | is_store | is_br | is_cmov | is_halt);

    assign imm_sel   = is_alui | is_load | is_store;
    assign br_mode   = is_br ? {1'b1, opcode_i[1:0]} : 3'b000;
    assign cont_edge = continue_i & ~continue_q;
    assign retired_o = retired_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_FETCH;
            wait_q     <= 8'd0;
            retired_q  <= '0;
            continue_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            retired_q  <= retired_d;
            continue_q <= continue_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        retired_d  = retired_q;
        loadPC_o   = 1'b0;
        writeReg_o = 1'b0;
        MemEn_o    = 1'b0;
        MemWen_o   = 1'b0;
        IMMsel_o   = 1'b0;
        DataSel_o  = 2'b00;
        BRANCH_o   = 3'b000;
        pwr_o      = 1'b1;
        halted_o   = 1'b0;
        fault_o    = 1'b0;

        case (state_q)
            S_FETCH: state_d = S_EXEC;

            S_EXEC: begin
                IMMsel_o = imm_sel;
                BRANCH_o = br_mode;
                wait_d   = 8'd0;
                if (is_load | is_store) state_d = S_MEM;
                else if (is_halt)       state_d = S_HALT;
                else if (is_illegal)    state_d = S_FAULT;
                else                    state_d = S_WB;
            end

            S_MEM: begin
                MemEn_o  = 1'b1;
                MemWen_o = is_store;
                IMMsel_o = 1'b1;
                wait_d   = wait_q + 8'd1;
                // wait_q counts completed MEM cycles, so WAIT_LAST marks the final allowed one
                if (mem_ready_i)              state_d = S_WB;
                else if (wait_q >= WAIT_LAST) state_d = S_FAULT;
            end

            S_WB: begin
                loadPC_o   = 1'b1;
                IMMsel_o   = imm_sel;
                BRANCH_o   = br_mode;
                writeReg_o = is_alur | is_alui | is_load | is_cmov;
                DataSel_o  = is_load ? 2'b01 : (is_cmov ? 2'b10 : 2'b00);
                retired_d  = retired_q + CNT_W'(1);
                state_d    = STEP_EN ? S_STEP : S_FETCH;
            end

            S_HALT: begin
                halted_o = 1'b1;
                if (cont_edge) state_d = S_WB;
            end

            S_STEP: begin
                halted_o = 1'b1;
                if (cont_edge) state_d = S_FETCH;
            end

            S_FAULT: begin
                fault_o  = 1'b1;
                halted_o = 1'b1;
                pwr_o    = 1'b0;
            end

            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_control_unit_ws.sv
// Directed bench for control_unit_ws: default instance (a) and a step-mode, 4-bit counter instance (b).
module tb_control_unit_ws;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic        rst_a, cont_a, mrdy_a;
    logic [3:0]  op_a;
    logic        lpc_a, wreg_a, men_a, mwen_a, imm_a, pwr_a, hlt_a, flt_a;
    logic [1:0]  dsel_a;
    logic [2:0]  br_a;
    logic [31:0] ret_a;

    logic        rst_b, cont_b, mrdy_b;
    logic [3:0]  op_b;
    logic        lpc_b, wreg_b, men_b, mwen_b, imm_b, pwr_b, hlt_b, flt_b;
    logic [1:0]  dsel_b;
    logic [2:0]  br_b;
    logic [3:0]  ret_b;

    control_unit_ws dut_a (
        .clk_i(clk), .reset_i(rst_a), .continue_i(cont_a), .opcode_i(op_a),
        .mem_ready_i(mrdy_a), .loadPC_o(lpc_a), .writeReg_o(wreg_a), .MemEn_o(men_a),
        .MemWen_o(mwen_a), .IMMsel_o(imm_a), .DataSel_o(dsel_a), .BRANCH_o(br_a),
        .pwr_o(pwr_a), .halted_o(hlt_a), .fault_o(flt_a), .retired_o(ret_a)
    );

    control_unit_ws #(.MEM_TIMEOUT(15), .CNT_W(4), .STEP_EN(1'b1)) dut_b (
        .clk_i(clk), .reset_i(rst_b), .continue_i(cont_b), .opcode_i(op_b),
        .mem_ready_i(mrdy_b), .loadPC_o(lpc_b), .writeReg_o(wreg_b), .MemEn_o(men_b),
        .MemWen_o(mwen_b), .IMMsel_o(imm_b), .DataSel_o(dsel_b), .BRANCH_o(br_b),
        .pwr_o(pwr_b), .halted_o(hlt_b), .fault_o(flt_b), .retired_o(ret_b)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_a = 1'b1; cont_a = 1'b0; mrdy_a = 1'b0; op_a = 4'b0000;
        rst_b = 1'b1; cont_b = 1'b0; mrdy_b = 1'b0; op_b = 4'b0000;
        tick(); tick();
        chk("rst_pwr", pwr_a, 1);
        chk("rst_halted", hlt_a, 0);
        chk("rst_fault", flt_a, 0);
        chk("rst_loadpc", lpc_a, 0);
        chk("rst_retired", ret_a, 0);
        rst_a = 1'b0;

        // ALU-reg: FETCH, EXEC, WB
        #1 chk("alu_fetch_lpc", lpc_a, 0);
        tick();
        chk("alu_exec_lpc", lpc_a, 0);
        chk("alu_exec_wreg", wreg_a, 0);
        tick();
        chk("alu_wb_lpc", lpc_a, 1);
        chk("alu_wb_wreg", wreg_a, 1);
        chk("alu_wb_dsel", dsel_a, 0);
        tick();
        chk("alu_fetch2_lpc", lpc_a, 0);
        chk("alu_retired", ret_a, 1);

        // LOAD with mem_ready on the 4th MEM cycle
        op_a = 4'b0010;
        tick();
        chk("ld_exec_imm", imm_a, 1);
        chk("ld_exec_men", men_a, 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("ld_mem%0d_men", i), men_a, 1);
            chk($sformatf("ld_mem%0d_mwen", i), mwen_a, 0);
        end
        mrdy_a = 1'b1;
        tick();
        mrdy_a = 1'b0;
        chk("ld_wb_men", men_a, 0);
        chk("ld_wb_wreg", wreg_a, 1);
        chk("ld_wb_dsel", dsel_a, 2'b01);
        chk("ld_wb_lpc", lpc_a, 1);
        tick();
        chk("ld_retired", ret_a, 2);

        // HALT with continue held high on entry
        op_a = 4'b1111; cont_a = 1'b1;
        tick();
        tick();
        chk("halt_halted", hlt_a, 1);
        chk("halt_lpc", lpc_a, 0);
        tick(); tick();
        chk("halt_held_halted", hlt_a, 1);
        cont_a = 1'b0;
        tick();
        chk("halt_low_halted", hlt_a, 1);
        cont_a = 1'b1;
        tick();
        chk("halt_rel_lpc", lpc_a, 1);
        chk("halt_rel_halted", hlt_a, 0);
        tick();
        cont_a = 1'b0;
        chk("halt_rel_fetch_lpc", lpc_a, 0);
        chk("halt_retired", ret_a, 3);

        // Branch 0101
        op_a = 4'b0101;
        tick();
        chk("br_exec_branch", br_a, 3'b101);
        tick();
        chk("br_wb_branch", br_a, 3'b101);
        chk("br_wb_lpc", lpc_a, 1);
        chk("br_wb_wreg", wreg_a, 0);
        tick();
        chk("br_retired", ret_a, 4);

        // Illegal opcode -> FAULT, continue ignored, reset exits
        op_a = 4'b1010;
        tick();
        chk("ill_exec_fault", flt_a, 0);
        tick();
        chk("ill_fault", flt_a, 1);
        chk("ill_halted", hlt_a, 1);
        chk("ill_pwr", pwr_a, 0);
        cont_a = 1'b1; tick(); cont_a = 1'b0; tick();
        chk("ill_cont_fault", flt_a, 1);
        rst_a = 1'b1;
        #1;
        chk("ill_rst_fault", flt_a, 0);
        chk("ill_rst_pwr", pwr_a, 1);
        chk("ill_rst_retired", ret_a, 0);
        tick();
        rst_a = 1'b0;

        // STORE never acknowledged -> FAULT after 15 MEM cycles
        op_a = 4'b0011;
        tick();
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk($sformatf("st_mem%0d_men", i), men_a, 1);
            chk($sformatf("st_mem%0d_mwen", i), mwen_a, 1);
            chk($sformatf("st_mem%0d_fault", i), flt_a, 0);
        end
        tick();
        chk("st_to_fault", flt_a, 1);
        chk("st_to_halted", hlt_a, 1);
        chk("st_to_pwr", pwr_a, 0);
        chk("st_to_men", men_a, 0);
        cont_a = 1'b1; tick(); cont_a = 1'b0; tick();
        chk("st_cont_fault", flt_a, 1);
        rst_a = 1'b1;
        #1;
        chk("st_rst_fault", flt_a, 0);
        chk("st_rst_halted", hlt_a, 0);
        tick();
        rst_a = 1'b0;
        tick();
        chk("st_rst_fetch_exec_men", men_a, 0);
        chk("st_rst_exec_imm", imm_a, 1);

        // Step mode, 4-bit retired counter wraps after 16 instructions
        rst_b = 1'b0;
        op_b = 4'b0000;
        for (int i = 1; i <= 16; i++) begin
            tick();
            tick();
            chk($sformatf("step%0d_wb_lpc", i), lpc_b, 1);
            tick();
            chk($sformatf("step%0d_halted", i), hlt_b, 1);
            chk($sformatf("step%0d_retired", i), ret_b, i % 16);
            cont_b = 1'b1;
            tick();
            chk($sformatf("step%0d_released", i), hlt_b, 0);
            cont_b = 1'b0;
        end
        chk("step_wrap_retired", ret_b, 0);

        // Reset mid-MEM drops MemEn before the next clock edge
        op_b = 4'b0010;
        tick();
        tick();
        chk("b_mem_men", men_b, 1);
        rst_b = 1'b1;
        #1;
        chk("b_rst_mid_mem_men", men_b, 0);
        chk("b_rst_mid_mem_halted", hlt_b, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
